// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// instruction geometry and the fetch-address legality check.
package fetch_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_ISSUE = 3'd1,
        FS_DRAIN = 3'd2,
        FS_HOLD  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_t;

    // Canonical NOP (addi x0, x0, 0) presented in place of a faulting fetch.
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    // A fetch is illegal when the pc is not word aligned or when its last
    // byte would fall outside memory. The sum is formed in 33 bits so a pc
    // near 2^32 cannot wrap around into the legal range.
    function automatic logic fetch_bad(input logic [31:0] pc,
                                       input logic [32:0] mem_limit);
        logic [32:0] last_byte;
        last_byte = {1'b0, pc} + 33'd3;
        return (pc[1:0] != 2'b00) || (last_byte >= mem_limit);
    endfunction

endpackage

// File: rtl/fetch_ctrl_byte_assembler.sv
// Collects four byte beats returned by the memory into a little-endian word.
// A beat is expected the cycle after each read strobe; flush drops any beat
// still in flight and restarts assembly at byte lane 0.
module byte_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        beat_en,
    input  logic [7:0]  beat_data,
    output logic [31:0] word,
    output logic        done
);

    logic        rd_pend_reg;
    logic [1:0]  cap_cnt_reg;
    logic [31:0] asm_reg;

    // Track outstanding reads and count captured beats; flush wins over capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_reg <= 1'b0;
            cap_cnt_reg <= 2'd0;
        end else if (flush) begin
            rd_pend_reg <= 1'b0;
            cap_cnt_reg <= 2'd0;
        end else begin
            rd_pend_reg <= beat_en;
            if (rd_pend_reg) begin
                cap_cnt_reg <= cap_cnt_reg + 2'd1;
            end
        end
    end

    // One capture register per byte lane, written when its beat arrives.
    generate
        for (genvar gi = 0; gi < INSTR_BYTES; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    asm_reg[gi*8 +: 8] <= 8'd0;
                end else if (!flush && rd_pend_reg && (cap_cnt_reg == 2'(gi))) begin
                    asm_reg[gi*8 +: 8] <= beat_data;
                end
            end
        end
    endgenerate

    // The final beat is merged combinationally so the word is usable on the
    // same edge that captures it.
    assign done = rd_pend_reg && (cap_cnt_reg == 2'd3) && !flush;
    assign word = {beat_data, asm_reg[23:0]};

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the pc, issues four byte reads per
// instruction, presents the assembled word with a valid/ready handshake and
// substitutes a NOP for misaligned or out-of-range fetches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault,
    output logic        busy
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [1:0]   iss_cnt_reg;
    logic         mem_en_reg;
    logic [31:0]  mem_addr_reg;
    logic         if_valid_reg;
    logic [31:0]  if_instr_reg;
    logic [31:0]  if_pc_reg;
    logic         if_fault_reg;
    logic         busy_reg;

    logic [31:0]  asm_word;
    logic         asm_done;

    // A redirect kills the read strobe in the very cycle it arrives, so no
    // byte of the abandoned fetch is requested after the flush.
    assign mem_en   = mem_en_reg & ~redirect_valid;
    assign mem_addr = mem_addr_reg;
    assign if_valid = if_valid_reg;
    assign if_instr = if_instr_reg;
    assign if_pc    = if_pc_reg;
    assign if_fault = if_fault_reg;
    assign busy     = busy_reg;

    byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .beat_en   (mem_en),
        .beat_data (mem_rdata),
        .word      (asm_word),
        .done      (asm_done)
    );

    // Fetch sequencer with registered outputs; redirect overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FS_IDLE;
            pc_reg       <= RESET_PC;
            iss_cnt_reg  <= 2'd0;
            mem_en_reg   <= 1'b0;
            mem_addr_reg <= 32'd0;
            if_valid_reg <= 1'b0;
            if_instr_reg <= 32'd0;
            if_pc_reg    <= 32'd0;
            if_fault_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else if (redirect_valid) begin
            state_reg    <= FS_IDLE;
            pc_reg       <= redirect_pc;
            iss_cnt_reg  <= 2'd0;
            mem_en_reg   <= 1'b0;
            if_valid_reg <= 1'b0;
            if_fault_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    if (fetch_en) begin
                        if (fetch_bad(pc_reg, MEM_LIMIT)) begin
                            state_reg    <= FS_FAULT;
                            if_valid_reg <= 1'b1;
                            if_fault_reg <= 1'b1;
                            if_instr_reg <= NOP_INSTR;
                            if_pc_reg    <= pc_reg;
                        end else begin
                            state_reg    <= FS_ISSUE;
                            iss_cnt_reg  <= 2'd0;
                            mem_en_reg   <= 1'b1;
                            mem_addr_reg <= pc_reg;
                            busy_reg     <= 1'b1;
                        end
                    end
                end
                FS_ISSUE: begin
                    if (iss_cnt_reg == 2'd3) begin
                        state_reg  <= FS_DRAIN;
                        mem_en_reg <= 1'b0;
                    end else begin
                        iss_cnt_reg  <= iss_cnt_reg + 2'd1;
                        mem_addr_reg <= pc_reg + {30'd0, iss_cnt_reg + 2'd1};
                    end
                end
                FS_DRAIN: begin
                    if (asm_done) begin
                        state_reg    <= FS_HOLD;
                        if_valid_reg <= 1'b1;
                        if_instr_reg <= asm_word;
                        if_pc_reg    <= pc_reg;
                        busy_reg     <= 1'b0;
                    end
                end
                FS_HOLD: begin
                    if (if_ready) begin
                        state_reg    <= FS_IDLE;
                        pc_reg       <= pc_reg + 32'(INSTR_BYTES);
                        if_valid_reg <= 1'b0;
                    end
                end
                FS_FAULT: begin
                    // Parked until a redirect supplies a new pc.
                    state_reg <= FS_FAULT;
                end
                default: begin
                    state_reg <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a byte-wide memory model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (1024),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read byte memory: data appears the cycle after the strobe.
    initial mem_rdata = 8'd0;
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem[a + k] = w[k*8 +: 8];
    endtask

    task automatic wait_mem_en(input string tag);
        int n;
        n = 0;
        while (mem_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, mem_en}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (if_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
        write_word(32'h000, 32'h0000_0293);
        write_word(32'h004, 32'h1234_5678);
        write_word(32'h05C, 32'h00B5_0533);
        write_word(32'h060, 32'h0000_0517);
        write_word(32'h3FC, 32'hDEAD_BEEF);

        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_fault", {31'd0, if_fault}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: first fetch, strobes in cycles 1..4, word in cycle 6.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_mem_en_c%0d", i + 1), {31'd0, mem_en}, 32'd1);
            chk($sformatf("t1_addr_c%0d", i + 1), mem_addr, 32'(i));
            tick();
        end
        chk("t1_c5_mem_en", {31'd0, mem_en}, 32'd0);
        chk("t1_c5_valid", {31'd0, if_valid}, 32'd0);
        chk("t1_c5_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_c6_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_c6_instr", if_instr, 32'h0000_0293);
        chk("t1_c6_pc", if_pc, 32'd0);
        chk("t1_c6_fault", {31'd0, if_fault}, 32'd0);
        $display("txn t1 instr=%h pc=%h", if_instr, if_pc);
        tick();
        wait_mem_en("t1_next_timeout");
        chk("t1_next_addr", mem_addr, 32'h4);

        // Test 2: back-pressure for the word at 4.
        if_ready = 1'b0;
        wait_valid("t2_valid_timeout");
        chk("t2_instr", if_instr, 32'h1234_5678);
        chk("t2_pc", if_pc, 32'h4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_valid", {31'd0, if_valid}, 32'd1);
            chk("t2_hold_instr", if_instr, 32'h1234_5678);
            chk("t2_hold_pc", if_pc, 32'h4);
            chk("t2_hold_mem_en", {31'd0, mem_en}, 32'd0);
        end
        $display("txn t2 instr=%h pc=%h held 10 cycles", if_instr, if_pc);
        if_ready = 1'b1;
        tick();
        chk("t2_released_valid", {31'd0, if_valid}, 32'd0);
        wait_mem_en("t2_next_timeout");
        chk("t2_next_addr", mem_addr, 32'h8);

        // Test 3: redirect while the third byte is being issued.
        tick();
        chk("t3_addr9", mem_addr, 32'h9);
        tick();
        chk("t3_addr10", mem_addr, 32'hA);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_005C;
        #1;
        chk("t3_redirect_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("t3_post_busy", {31'd0, busy}, 32'd0);
        chk("t3_post_valid", {31'd0, if_valid}, 32'd0);
        wait_mem_en("t3_next_timeout");
        chk("t3_next_addr", mem_addr, 32'h5C);
        wait_valid("t3_valid_timeout");
        chk("t3_instr", if_instr, 32'h00B5_0533);
        chk("t3_pc", if_pc, 32'h5C);
        chk("t3_fault", {31'd0, if_fault}, 32'd0);
        $display("txn t3 instr=%h pc=%h", if_instr, if_pc);
        fetch_en = 1'b0;
        tick();
        chk("t3_idle_mem_en", {31'd0, mem_en}, 32'd0);

        // Test 4: misaligned redirect faults, handshakes do not leave FAULT.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0062;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_fault_valid", {31'd0, if_valid}, 32'd1);
            chk("t4_fault_flag", {31'd0, if_fault}, 32'd1);
            chk("t4_fault_instr", if_instr, 32'h0000_0013);
            chk("t4_fault_pc", if_pc, 32'h62);
            chk("t4_fault_mem_en", {31'd0, mem_en}, 32'd0);
            tick();
        end
        $display("txn t4 fault instr=%h pc=%h", if_instr, if_pc);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0060;
        tick();
        redirect_valid = 1'b0;
        chk("t4_recover_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_recover_fault", {31'd0, if_fault}, 32'd0);
        wait_mem_en("t4_next_timeout");
        chk("t4_next_addr", mem_addr, 32'h60);
        wait_valid("t4_valid_timeout");
        chk("t4_instr", if_instr, 32'h0000_0517);
        chk("t4_pc", if_pc, 32'h60);
        $display("txn t4 instr=%h pc=%h", if_instr, if_pc);

        // Redirect together with handshake: word taken, pc goes to 0x3FC.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_03FC;
        tick();
        redirect_valid = 1'b0;
        chk("t6_rh_valid", {31'd0, if_valid}, 32'd0);
        wait_mem_en("t5_next_timeout");
        chk("t5_addr_3fc", mem_addr, 32'h3FC);

        // Test 5: last legal word, then range and wrap faults.
        wait_valid("t5_valid_timeout");
        chk("t5_instr", if_instr, 32'hDEAD_BEEF);
        chk("t5_pc", if_pc, 32'h3FC);
        chk("t5_fault", {31'd0, if_fault}, 32'd0);
        $display("txn t5 instr=%h pc=%h", if_instr, if_pc);
        tick();
        chk("t5_idle_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        chk("t5_range_mem_en", {31'd0, mem_en}, 32'd0);
        chk("t5_range_fault", {31'd0, if_fault}, 32'd1);
        chk("t5_range_pc", if_pc, 32'h400);
        chk("t5_range_instr", if_instr, 32'h0000_0013);
        $display("txn t5 fault pc=%h", if_pc);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t5_wrap_fault", {31'd0, if_fault}, 32'd1);
        chk("t5_wrap_valid", {31'd0, if_valid}, 32'd1);
        chk("t5_wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_wrap_mem_en", {31'd0, mem_en}, 32'd0);
        $display("txn t5 wrap fault pc=%h", if_pc);

        // Test 6: asynchronous reset during DRAIN.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        tick();
        redirect_valid = 1'b0;
        wait_mem_en("t6_fetch_timeout");
        chk("t6_addr", mem_addr, 32'h10);
        repeat (4) tick();
        chk("t6_drain_busy", {31'd0, busy}, 32'd1);
        chk("t6_drain_mem_en", {31'd0, mem_en}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        chk("t6_async_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_held_valid", {31'd0, if_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_restart_mem_en", {31'd0, mem_en}, 32'd1);
        chk("t6_restart_addr", mem_addr, 32'h0);
        wait_valid("t6_valid_timeout");
        chk("t6_instr", if_instr, 32'h0000_0293);
        chk("t6_pc", if_pc, 32'h0);
        $display("txn t6 instr=%h pc=%h", if_instr, if_pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
